puf_uart_bridge: RTL

//  Command/response framer sitting directly downstream of the uart RX port and upstream of its TX port.

---
 rtl/puf_uart_bridge.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/puf_uart_bridge.sv
// puf_uart_bridge: UART byte framer feeding a PUF with challenges and
// streaming its responses back out, one frame in flight at a time.
// Ports: clk/resetn (async, active low); rx_data/rx_valid/rx_enable from
// the UART receiver; tx_data/tx_enable/tx_busy to the UART transmitter;
// challenge/puf_start/puf_done/response to the PUF; busy, timeout_err.
// Build option PUF_BRIDGE_CHECKSUM_EN: XOR trailer byte on both frames,
// NAK (8'h15) reply on a bad challenge checksum.
module puf_uart_bridge #(
   parameter int DATA_BITS       = 8,
   parameter int CHALLENGE_BYTES = 4,
   parameter int RESPONSE_BYTES  = 4,
   parameter int TIMEOUT_CYCLES  = 5_000_000
) (
   input  logic                                 clk,
   input  logic                                 resetn,
   input  logic [DATA_BITS-1:0]                 rx_data,
   input  logic                                 rx_valid,
   output logic                                 rx_enable,
   output logic [DATA_BITS-1:0]                 tx_data,
   output logic                                 tx_enable,
   input  logic                                 tx_busy,
   output logic [CHALLENGE_BYTES*DATA_BITS-1:0] challenge,
   output logic                                 puf_start,
   input  logic                                 puf_done,
   input  logic [RESPONSE_BYTES*DATA_BITS-1:0]  response,
   output logic                                 busy,
   output logic                                 timeout_err
);

`ifdef PUF_BRIDGE_CHECKSUM_EN
   localparam int CK = 1;
`else
   localparam int CK = 0;
`endif
   localparam int FRAME = CHALLENGE_BYTES + CK;
   localparam int TXMAX = RESPONSE_BYTES + CK;
   localparam int CMAX  = (FRAME > TXMAX) ? FRAME : TXMAX;
   localparam int CNT_W = $clog2(CMAX + 1);
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
   localparam int CW    = CHALLENGE_BYTES * DATA_BITS;
   localparam int SW    = TXMAX * DATA_BITS;

   localparam logic [CNT_W-1:0] FRAME_C = CNT_W'(FRAME);
   localparam logic [CNT_W-1:0] CB_C    = CNT_W'(CHALLENGE_BYTES);
   localparam logic [CNT_W-1:0] TXMAX_C = CNT_W'(TXMAX);
   localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_RX, S_START, S_PUF_WAIT, S_TX_REQ, S_TX_ACK, S_TX_DONE
   } state_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, tx_idx, tx_last;
   logic [TMR_W-1:0] tmr;
   logic [CW-1:0]    chal;
   logic [SW-1:0]    sreg;
   logic [SW-1:0]    resp_frame;
   logic             rx_en_q;
   logic             frame_full, accept, expire, tx_final, go_start;

   // A full frame is consumed on the following cycle, so no byte is
   // accepted and the timer cannot fire while it is pending.
   assign frame_full = (cnt == FRAME_C);
   assign accept = (state == S_RX) && rx_valid && !frame_full;
   assign expire = (state == S_RX) && (cnt != '0) && !frame_full
                && (tmr == TMR_MAX) && !rx_valid;
   assign tx_final = ((tx_idx + 1'b1) == tx_last);

`ifdef PUF_BRIDGE_CHECKSUM_EN
   localparam logic [DATA_BITS-1:0] NAK = DATA_BITS'(8'h15);
   logic [DATA_BITS-1:0] rx_x, resp_x;
   logic                 ck_ok;

   always_comb begin
      resp_x = '0;
      for (int i = 0; i < RESPONSE_BYTES; i++)
         resp_x = resp_x ^ response[i*DATA_BITS +: DATA_BITS];
   end

   assign resp_frame = {response, resp_x};
   assign go_start   = ck_ok;

   // Running XOR of the challenge bytes; the trailer byte is compared
   // against it instead of being shifted into the challenge.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rx_x  <= '0;
         ck_ok <= 1'b0;
      end else if (accept) begin
         if (cnt == '0)
            rx_x <= rx_data;
         else if (cnt != CB_C)
            rx_x <= rx_x ^ rx_data;
         else
            ck_ok <= (rx_data == rx_x);
      end
   end
`else
   assign resp_frame = response;
   assign go_start   = 1'b1;
`endif

   always_comb begin
      state_n = state;
      unique case (state)
         S_RX:       if (frame_full)
                        state_n = go_start ? S_START : S_TX_REQ;
         S_START:    state_n = S_PUF_WAIT;
         S_PUF_WAIT: if (puf_done) state_n = S_TX_REQ;
         S_TX_REQ:   if (!tx_busy) state_n = S_TX_ACK;
         S_TX_ACK:   if (tx_busy) state_n = S_TX_DONE;
         S_TX_DONE:  if (!tx_busy)
                        state_n = tx_final ? S_RX : S_TX_REQ;
         default:    state_n = S_RX;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state   <= S_RX;
         rx_en_q <= 1'b0;
         cnt     <= '0;
         tmr     <= '0;
         chal    <= '0;
         sreg    <= '0;
         tx_idx  <= '0;
         tx_last <= '0;
      end else begin
         state   <= state_n;
         rx_en_q <= (state_n == S_RX);
         if (accept) begin
            cnt <= cnt + 1'b1;
            tmr <= '0;
            if (cnt != CB_C)
               chal <= (chal << DATA_BITS) | CW'(rx_data);
         end else if (expire) begin
            cnt <= '0;
            tmr <= '0;
         end else if ((state == S_RX) && (cnt != '0) && (tmr != TMR_MAX)) begin
            tmr <= tmr + 1'b1;
         end
         if ((state == S_RX) && frame_full) begin
            cnt <= '0;
`ifdef PUF_BRIDGE_CHECKSUM_EN
            if (!ck_ok) begin
               sreg    <= SW'(NAK) << (SW - DATA_BITS);
               tx_idx  <= '0;
               tx_last <= CNT_W'(1);
            end
`endif
         end
         if ((state == S_PUF_WAIT) && puf_done) begin
            sreg    <= resp_frame;
            tx_idx  <= '0;
            tx_last <= TXMAX_C;
         end
         if ((state == S_TX_DONE) && !tx_busy) begin
            sreg   <= sreg << DATA_BITS;
            tx_idx <= tx_idx + 1'b1;
         end
      end
   end

   assign rx_enable   = rx_en_q;
   assign tx_data     = sreg[SW-1 -: DATA_BITS];
   assign tx_enable   = (state == S_TX_REQ) && !tx_busy;
   assign challenge   = chal;
   assign puf_start   = (state == S_START);
   assign busy        = !((state == S_RX) && (cnt == '0));
   assign timeout_err = expire;

endmodule
